fifo_addr_counter: RTL and testbench
====================================

# fifo_addr_counter

Modulo address counter that generates the read or write pointer for the FIFO memory. It advances by one on each enabled clock and wraps from `DEPTH-1` to 0. On each wrap it toggles a lap bit, which the FIFO uses to tell full from empty. It also provides synchronous clear, parallel load and a terminal-count flag, plus an optional registered Gray-coded copy of the address.

## Interface
- `COUNTER_WIDTH`, default 3: width of `addr` and `load_val`.
- `DEPTH`, default `2**COUNTER_WIDTH`: modulus, legal range 2..`2**COUNTER_WIDTH`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low. `reset`=0 forces all state to reset values immediately.
- `en` input 1: count enable; increment by one per cycle while high.
- `clear` input 1: synchronous clear of `addr` and `wrap`.
- `load` input 1: synchronous parallel load of `addr` from `load_val`.
- `load_val` input `COUNTER_WIDTH`: value to load.
- `addr` output `COUNTER_WIDTH`: registered current address.
- `wrap` output 1: registered lap bit; toggles on every wrap.
- `tc` output 1: combinational terminal count, `addr == DEPTH-1`.
- `addr_gray` output `COUNTER_WIDTH`: registered Gray code of `addr` (see Configuration).

## Operation
- Reset values while `reset`=0:
  - `addr`=0, `wrap`=0, `addr_gray`=0.
  - `tc`=0, or 1 only if `DEPTH`=1, which is illegal.
- Next-state priority per rising edge, highest first: `clear`, `load`, `en`, hold.
- `clear`=1: `addr`←0, `wrap`←0.
- `load`=1:
  - `addr`←`load_val`.
  - `load_val` ≥ `DEPTH` is clamped to `DEPTH-1`.
  - `wrap` unchanged.
- `en`=1:
  - If `addr`=`DEPTH-1`: `addr`←0 and `wrap`←~`wrap`.
  - Otherwise: `addr`←`addr`+1.
- None asserted: hold all state.
- Arithmetic is unsigned, `COUNTER_WIDTH` bits. The increment never produces a value ≥ `DEPTH`.
- `tc` is independent of `en`.
- Any mix of `clear`/`load`/`en` in one cycle resolves strictly by the priority above; there are no combined effects.

## Timing
- Latency is 1 cycle from a control input sampled at the edge to `addr`/`wrap` update.
- `tc` follows `addr` combinationally, in the same cycle as the new `addr`.
- `addr_gray` is computed from the next `addr` value and registered on the same edge. It is therefore always coherent with `addr`, with no extra cycle of lag.
- Reset assertion mid-count takes effect asynchronously without waiting for a clock edge. Deassertion is released on clock; the first count occurs on the first rising edge after `reset` returns to 1 with `en`=1.
- Full wrap period is `DEPTH` enabled cycles. `wrap` period is `2*DEPTH` enabled cycles.

## Configuration
- Macro `FIFO_COUNTER_GRAY_EN`.
- Defined:
  - `addr_gray` = registered `next_addr ^ (next_addr >> 1)`.
  - Exactly one bit changes per increment when `DEPTH` = `2**COUNTER_WIDTH`, including at wrap.
  - Intended for clock-domain-crossing pointer transfer.
- Undefined:
  - No Gray logic is built and `addr_gray` is tied to constant 0.
  - All other behaviour is identical.

## Test plan
- Reset, then `en`=1 for 9 cycles, `COUNTER_WIDTH`=3, default `DEPTH`:
  - `addr` sequence 1,2,…,7,0,1.
  - `tc`=1 only while `addr`=7.
  - `wrap` 0→1 at the 7→0 edge.
- `DEPTH`=5, `en`=1 for 12 cycles: `addr` 1,2,3,4,0,1,2,3,4,0,1,2; `wrap` toggles at each 4→0 step.
- Simultaneous `clear`=1, `load`=1 (`load_val`=6), `en`=1 at `addr`=3 → next `addr`=0, `wrap`=0. Then `load`=1, `en`=1 → `addr`=6, `wrap` unchanged.
- `load_val`=7 with `DEPTH`=5 → `addr`=4, `tc`=1. The next `en` cycle gives `addr`=0 and toggles `wrap`.
- Assert `reset`=0 mid-clock-period at `addr`=5 → `addr`, `wrap` and `addr_gray` go to 0 before the next edge. They hold 0 while `en`=1 until `reset` returns to 1.
- With `FIFO_COUNTER_GRAY_EN`, 16 enabled cycles: `addr_gray` follows 0,1,3,2,6,7,5,4 repeating. Consecutive values differ by exactly one bit, including 4→0.

Source files
------------

// File: rtl/fifo_addr_counter_if.sv
// rtl/fifo_addr_counter_if.sv - control/status bundle between a FIFO and its address counter
//
// Purpose: groups the counter's control inputs and status outputs.
//   master modport (FIFO side): drives en, clear, load, load_val; observes addr, wrap, tc, addr_gray
//   slave  modport (counter)  : observes en, clear, load, load_val; drives addr, wrap, tc, addr_gray
interface fifo_addr_counter_if #(
  parameter int COUNTER_WIDTH = 3
);
  logic                     en;
  logic                     clear;
  logic                     load;
  logic [COUNTER_WIDTH-1:0] load_val;
  logic [COUNTER_WIDTH-1:0] addr;
  logic                     wrap;
  logic                     tc;
  logic [COUNTER_WIDTH-1:0] addr_gray;

  modport master (
    output en, clear, load, load_val,
    input  addr, wrap, tc, addr_gray
  );

  modport slave (
    input  en, clear, load, load_val,
    output addr, wrap, tc, addr_gray
  );
endinterface

// File: rtl/fifo_addr_counter.sv
// rtl/fifo_addr_counter.sv - modulo-DEPTH FIFO pointer with lap bit, clear, load, terminal count
//
// Purpose: read/write pointer generator for FIFO memory. Counts 0..DEPTH-1 and
// toggles the lap bit (wrap) on every DEPTH-1 -> 0 step so the FIFO can tell
// full from empty.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - fifo_addr_counter_if.slave: en, clear, load, load_val in;
//           addr, wrap, addr_gray (registered) and tc (combinational) out
// Parameters: COUNTER_WIDTH (addr width), DEPTH (modulus, 2..2**COUNTER_WIDTH)
// Optional feature macro: FIFO_COUNTER_GRAY_EN (registered Gray copy of addr;
// when undefined addr_gray is constant 0).
module fifo_addr_counter #(
  parameter int COUNTER_WIDTH = 3,
  parameter int DEPTH         = 2 ** COUNTER_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  fifo_addr_counter_if.slave  bus
);

  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(DEPTH - 1);
  localparam logic [COUNTER_WIDTH-1:0] ONE  = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] r_addr;
  logic                     r_wrap;
  logic [COUNTER_WIDTH-1:0] w_next_addr;
  logic                     w_next_wrap;
  logic [COUNTER_WIDTH-1:0] w_load_clamped;

  // Out-of-range load values would escape the modulus; pin them to the last slot.
  assign w_load_clamped = (bus.load_val > LAST) ? LAST : bus.load_val;

  // Strict priority: clear, load, en, hold.
  always_comb begin
    w_next_addr = r_addr;
    w_next_wrap = r_wrap;
    if (bus.clear) begin
      w_next_addr = '0;
      w_next_wrap = 1'b0;
    end else if (bus.load) begin
      w_next_addr = w_load_clamped;
    end else if (bus.en) begin
      if (r_addr == LAST) begin
        w_next_addr = '0;
        w_next_wrap = ~r_wrap;
      end else begin
        w_next_addr = r_addr + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_addr <= w_next_addr;
      r_wrap <= w_next_wrap;
    end
  end

  assign bus.addr = r_addr;
  assign bus.wrap = r_wrap;
  assign bus.tc   = (r_addr == LAST);

`ifdef FIFO_COUNTER_GRAY_EN
  // Encoded from the next address so the Gray copy lands on the same edge as addr.
  logic [COUNTER_WIDTH-1:0] r_gray;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gray <= '0;
    end else begin
      r_gray <= w_next_addr ^ (w_next_addr >> 1);
    end
  end

  assign bus.addr_gray = r_gray;
`else
  assign bus.addr_gray = '0;
`endif

endmodule

// File: tb/tb_fifo_addr_counter.sv
// tb/tb_fifo_addr_counter.sv - scoreboard bench for fifo_addr_counter (DEPTH 8 and DEPTH 5)
module tb_fifo_addr_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_addr_counter_if #(.COUNTER_WIDTH(3)) bus0 ();
  fifo_addr_counter_if #(.COUNTER_WIDTH(3)) bus1 ();

  fifo_addr_counter #(.COUNTER_WIDTH(3)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  fifo_addr_counter #(.COUNTER_WIDTH(3), .DEPTH(5)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  typedef struct {
    logic [2:0] addr;
    logic       wrap;
    logic       tc;
    logic [2:0] gray;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  int dep[2] = '{8, 5};
  int ma[2]  = '{0, 0};
  int mw[2]  = '{0, 0};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t e;
    e.addr = 3'(ma[k]);
    e.wrap = (mw[k] != 0);
    e.tc   = (ma[k] == dep[k] - 1);
`ifdef FIFO_COUNTER_GRAY_EN
    e.gray = 3'(ma[k] ^ (ma[k] / 2));
`else
    e.gray = 3'd0;
`endif
    return e;
  endfunction

  // Drives one cycle of stimulus after the edge and queues the state expected after the next edge.
  task automatic step(input logic rst_v, input logic e, input logic c, input logic l,
                      input logic [2:0] lv);
    @(posedge clk);
    #2;
    reset = rst_v;
    bus0.en = e; bus0.clear = c; bus0.load = l; bus0.load_val = lv;
    bus1.en = e; bus1.clear = c; bus1.load = l; bus1.load_val = lv;
    for (int k = 0; k < 2; k++) begin
      if (!rst_v) begin
        ma[k] = 0; mw[k] = 0;
      end else if (c) begin
        ma[k] = 0; mw[k] = 0;
      end else if (l) begin
        ma[k] = (int'(lv) >= dep[k]) ? dep[k] - 1 : int'(lv);
      end else if (e) begin
        ma[k] = (ma[k] + 1) % dep[k];
        if (ma[k] == 0) mw[k] = 1 - mw[k];
      end
    end
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    if (!rst_v) begin
      // Asynchronous reset must already have cleared state before the next edge.
      #1;
      check("async_rst_addr0", int'(bus0.addr), 0);
      check("async_rst_wrap0", int'(bus0.wrap), 0);
      check("async_rst_gray0", int'(bus0.addr_gray), 0);
      check("async_rst_addr1", int'(bus1.addr), 0);
      check("async_rst_wrap1", int'(bus1.wrap), 0);
    end
  endtask

  // Monitor: the counter presents a fresh output every cycle; compare against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("d8_addr", int'(bus0.addr), int'(e.addr));
        check("d8_wrap", int'(bus0.wrap), int'(e.wrap));
        check("d8_tc",   int'(bus0.tc),   int'(e.tc));
        check("d8_gray", int'(bus0.addr_gray), int'(e.gray));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("d5_addr", int'(bus1.addr), int'(e.addr));
        check("d5_wrap", int'(bus1.wrap), int'(e.wrap));
        check("d5_tc",   int'(bus1.tc),   int'(e.tc));
        check("d5_gray", int'(bus1.addr_gray), int'(e.gray));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.en = 0; bus0.clear = 0; bus0.load = 0; bus0.load_val = 0;
    bus1.en = 0; bus1.clear = 0; bus1.load = 0; bus1.load_val = 0;
    #1;
    check("reset_addr",  int'(bus0.addr), 0);
    check("reset_wrap",  int'(bus0.wrap), 0);
    check("reset_tc",    int'(bus0.tc), 0);
    check("reset_gray",  int'(bus0.addr_gray), 0);
    check("reset_tc_d5", int'(bus1.tc), 0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    // Count sequence through wrap on both moduli.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    // Priority: clear beats load and en; then load beats en.
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'd6);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'd6);
    // Clamp on the DEPTH=5 counter, then wrap from the clamped terminal value.
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    // Mid-count asynchronous reset with en held high.
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    // Full Gray cycle (16 enabled cycles).
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    // Randomized mix.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 64) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
           ($urandom % 8) == 0, 3'($urandom));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    #3;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
